// File: rtl/cache_fill_fsm_pkg.sv
// Purpose : shared constants for the cache block fill sequencer.
// Latency : n/a (constants only).
// Backpres: n/a.
// Contents: block geometry, block alignment mask, FSM state encodings.
package cache_fill_fsm_pkg;

   // One cache block is 8 x 16-bit words = 16 bytes.
   localparam int          BLOCK_WORDS       = 8;
   // Clears the byte offset within a 16-byte block.
   localparam logic [15:0] BLOCK_OFFSET_MASK = 16'hFFF0;

   // FSM state encodings, kept as plain vectors for legacy netlist compatibility.
   localparam logic [0:0]  IDLE              = 1'b0;
   localparam logic [0:0]  FILL              = 1'b1;

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Purpose : CNT_W-bit up-counter with synchronous clear and increment enable.
// Latency : count updates at the edge following clr/inc.
// Backpres: none; clr has priority over inc.
// Ports   : clk, rst (async active-low), clr, inc -> count.
module fill_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/cache_fill_fsm.sv
// Purpose : on a cache miss, fetch one 16-byte block word by word and fill the data/tag arrays.
// Latency : requests start the cycle after the miss is sampled; busy ends the cycle after the tag write.
// Backpres: none upstream beyond fsm_busy; gaps in memory_data_valid simply stretch the fill.
// Ports   : miss_detected/miss_address in; mem_read_en/memory_address to memory;
//           memory_data_valid/memory_data from memory; write_data_array/fill_word_idx/
//           write_tag_array to the cache arrays; fsm_busy stalls the pipeline.
module cache_fill_fsm
   import cache_fill_fsm_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int WORDS  = BLOCK_WORDS,
   parameter int CNT_W  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     miss_detected,
   input  logic [ADDR_W-1:0]        miss_address,
   input  logic                     memory_data_valid,
   input  logic [ADDR_W-1:0]        memory_data,
   output logic                     fsm_busy,
   output logic                     mem_read_en,
   output logic [ADDR_W-1:0]        memory_address,
   output logic                     write_data_array,
   output logic [$clog2(WORDS)-1:0] fill_word_idx,
   output logic                     write_tag_array
);

   logic [0:0]        state;
   logic [0:0]        state_nxt;
   logic [ADDR_W-1:0] base;
   logic [CNT_W-1:0]  issue_cnt;
   logic [CNT_W-1:0]  rcv_cnt;
   logic              in_fill;
   logic              start_fill;
   logic              last_word;

   // The returned word goes straight to the data array's write port outside
   // this block; the sequencer itself never looks at its value.
   logic              unused_mem_data;
   assign unused_mem_data = ^memory_data;

   assign in_fill    = (state == FILL);
   // Misses are only accepted while idle; a miss during a fill is dropped.
   assign start_fill = (state == IDLE) && miss_detected;
   assign last_word  = in_fill && memory_data_valid && (rcv_cnt == CNT_W'(WORDS - 1));

   always_comb begin
      state_nxt = state;
      if (start_fill) begin
         state_nxt = FILL;
      end else if (last_word) begin
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Block-aligned base address, loaded only when a new fill starts.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         base <= '0;
      end else if (start_fill) begin
         base <= miss_address & ADDR_W'(BLOCK_OFFSET_MASK);
      end
   end

   // Requests are issued back to back independent of responses; the memory
   // is pipelined and returns words in request order.
   fill_counter #(.CNT_W(CNT_W)) u_issue_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (start_fill),
      .inc   (mem_read_en),
      .count (issue_cnt)
   );

   fill_counter #(.CNT_W(CNT_W)) u_rcv_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (start_fill),
      .inc   (write_data_array),
      .count (rcv_cnt)
   );

   assign fsm_busy         = in_fill;
   assign mem_read_en      = in_fill && (issue_cnt < CNT_W'(WORDS));
   // Word address = base + 2 * word index (16-bit words, byte addressing).
   assign memory_address   = in_fill ? (base + (ADDR_W'(issue_cnt) << 1)) : '0;
   // Valid responses while idle are stale (e.g. issued before a reset) and are dropped.
   assign write_data_array = in_fill && memory_data_valid;
   assign fill_word_idx    = rcv_cnt[$clog2(WORDS)-1:0];
   assign write_tag_array  = last_word;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Purpose : self-checking bench for cache_fill_fsm with a 4-cycle pipelined memory model.
// Latency : memory returns data = request address, 4 cycles after the request (plus optional gaps).
// Backpres: none; all waits on the DUT are cycle-bounded.
module tb_cache_fill_fsm;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        miss_detected = 1'b0;
   logic [15:0] miss_address = 16'h0;
   logic        memory_data_valid = 1'b0;
   logic [15:0] memory_data = 16'h0;
   logic        fsm_busy;
   logic        mem_read_en;
   logic [15:0] memory_address;
   logic        write_data_array;
   logic [2:0]  fill_word_idx;
   logic        write_tag_array;

   cache_fill_fsm dut (
      .clk               (clk),
      .rst               (rst),
      .miss_detected     (miss_detected),
      .miss_address      (miss_address),
      .memory_data_valid (memory_data_valid),
      .memory_data       (memory_data),
      .fsm_busy          (fsm_busy),
      .mem_read_en       (mem_read_en),
      .memory_address    (memory_address),
      .write_data_array  (write_data_array),
      .fill_word_idx     (fill_word_idx),
      .write_tag_array   (write_tag_array)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // ---------------- memory model ----------------
   typedef struct {
      int          ready;
      logic [15:0] addr;
   } mem_req_t;

   mem_req_t mem_q[$];
   int       last_ready = 0;
   bit       gap_mode = 1'b0;
   int       mem_r;
   mem_req_t mem_e;

   // Requests are captured mid-cycle; the word comes back 4 cycles later, in order.
   always @(negedge clk) begin
      if (rst && mem_read_en) begin
         mem_r = cyc + 4;
         if (mem_r < last_ready + 1) mem_r = last_ready + 1;
         if (gap_mode) mem_r = mem_r + $urandom_range(0, 3);
         last_ready = mem_r;
         mem_e.ready = mem_r;
         mem_e.addr  = memory_address;
         mem_q.push_back(mem_e);
      end
   end

   // Keeps delivering outstanding responses even across a DUT reset.
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
         memory_data_valid = 1'b1;
         memory_data       = mem_q[0].addr;
         void'(mem_q.pop_front());
      end else begin
         memory_data_valid = 1'b0;
         memory_data       = 16'h0;
      end
   end

   // ---------------- scoreboard ----------------
   logic [15:0] exp_req_q[$];
   logic [19:0] exp_wr_q[$];   // {tag, idx[2:0], data[15:0]}

   typedef struct packed {
      logic [7:0] busy0;
      logic [7:0] n_req;
      logic [7:0] first_req;
      logic [7:0] last_req;
      logic [7:0] n_wr;
      logic [7:0] first_wr;
      logic [7:0] n_busy;
      logic [7:0] tag_rel;
   } fill_res_t;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Samples one cycle mid-way and pops/compares any request or write seen.
   task automatic sb_sample(input string tag);
      logic [15:0] er;
      logic [19:0] ew;
      @(negedge clk);
      if (mem_read_en) begin
         vectors++;
         if (exp_req_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s_req: got request addr %h, required no request", tag, memory_address);
         end else begin
            er = exp_req_q.pop_front();
            if (memory_address !== er) begin
               miscompares++;
               $display("FAIL %s_req: got addr %h, required %h", tag, memory_address, er);
            end
         end
      end
      if (write_data_array) begin
         vectors++;
         if (exp_wr_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s_wr: got write idx %0d data %h, required no write", tag, fill_word_idx, memory_data);
         end else begin
            ew = exp_wr_q.pop_front();
            if ({write_tag_array, fill_word_idx, memory_data} !== ew) begin
               miscompares++;
               $display("FAIL %s_wr: got tag=%b idx=%0d data=%h, required tag=%b idx=%0d data=%h",
                        tag, write_tag_array, fill_word_idx, memory_data, ew[19], ew[18:16], ew[15:0]);
            end
         end
      end else begin
         vectors++;
         if (write_tag_array !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_tag: got tag pulse without data write, required 0", tag);
         end
      end
   endtask

   // Drives a miss in the current cycle (cycle 0) and follows the fill to its tag pulse.
   // Returns at the first cycle after the tag pulse.
   task automatic run_fill(input string tag, input logic [15:0] addr, input int inject_rel,
                           input logic [15:0] inject_addr, output fill_res_t res);
      logic [15:0] b;
      bit          done;
      res = '0;
      res.first_req = 8'hFF;
      res.first_wr  = 8'hFF;
      res.tag_rel   = 8'hFF;
      b = addr & 16'hFFF0;
      for (int i = 0; i < 8; i++) begin
         exp_req_q.push_back(b + 16'(2 * i));
         exp_wr_q.push_back({(i == 7) ? 1'b1 : 1'b0, 3'(i), b + 16'(2 * i)});
      end
      miss_detected = 1'b1;
      miss_address  = addr;
      sb_sample(tag);
      res.busy0 = {7'd0, fsm_busy};
      tick();
      miss_detected = 1'b0;
      miss_address  = 16'h0;
      done = 1'b0;
      for (int rel = 1; rel <= 60 && !done; rel++) begin
         if (rel == inject_rel) begin
            miss_detected = 1'b1;
            miss_address  = inject_addr;
         end else begin
            miss_detected = 1'b0;
         end
         sb_sample(tag);
         if (fsm_busy) res.n_busy++;
         if (mem_read_en) begin
            res.n_req++;
            if (res.first_req == 8'hFF) res.first_req = 8'(rel);
            res.last_req = 8'(rel);
         end
         if (write_data_array) begin
            res.n_wr++;
            if (res.first_wr == 8'hFF) res.first_wr = 8'(rel);
         end
         if (write_tag_array) begin
            res.tag_rel = 8'(rel);
            done = 1'b1;
         end
         tick();
      end
      miss_detected = 1'b0;
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_timeout: got no tag pulse within 60 cycles, required one", tag);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #3 rst = 1'b0;
      #1;
      vectors++;
      if ({fsm_busy, mem_read_en, memory_address, write_data_array, fill_word_idx, write_tag_array} !== 22'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: got busy=%b rd=%b addr=%h wda=%b idx=%0d tag=%b, required all 0",
                  fsm_busy, mem_read_en, memory_address, write_data_array, fill_word_idx, write_tag_array);
      end
      tick();
      tick();
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         sb_sample("idle");
         vectors++;
         if ({fsm_busy, mem_read_en, write_data_array, write_tag_array} !== 4'b0000) begin
            miscompares++;
            $display("FAIL idle_cycle%0d: got busy=%b rd=%b wda=%b tag=%b, required 0000",
                     i, fsm_busy, mem_read_en, write_data_array, write_tag_array);
         end
         tick();
      end
   endtask

   task automatic test_basic_fill();
      fill_res_t r;
      fill_res_t e;
      run_fill("basic", 16'h1236, 0, 16'h0, r);
      e = '{busy0: 8'd0, n_req: 8'd8, first_req: 8'd1, last_req: 8'd8,
            n_wr: 8'd8, first_wr: 8'd5, n_busy: 8'd12, tag_rel: 8'd12};
      vectors++;
      if (r !== e) begin
         miscompares++;
         $display("FAIL basic_timing: got busy0/nreq/freq/lreq/nwr/fwr/nbusy/tag=%h, required %h", r, e);
      end
      sb_sample("basic_end");
      vectors++;
      if ({fsm_busy, mem_read_en, memory_address} !== 18'h0) begin
         miscompares++;
         $display("FAIL basic_busy_fall: got busy=%b rd=%b addr=%h, required 0 0 0000",
                  fsm_busy, mem_read_en, memory_address);
      end
      vectors++;
      if (exp_req_q.size() + exp_wr_q.size() != 0) begin
         miscompares++;
         $display("FAIL basic_drain: got %0d expectations left, required 0", exp_req_q.size() + exp_wr_q.size());
      end
      tick();
   endtask

   task automatic test_miss_during_fill();
      fill_res_t r;
      run_fill("midmiss", 16'h1236, 3, 16'hABC0, r);
      vectors++;
      if ({r.n_req, r.n_wr, r.tag_rel} !== {8'd8, 8'd8, 8'd12}) begin
         miscompares++;
         $display("FAIL midmiss_counts: got req=%0d wr=%0d tag_cycle=%0d, required 8 8 12", r.n_req, r.n_wr, r.tag_rel);
      end
      sb_sample("midmiss_end");
      vectors++;
      if ({fsm_busy, mem_read_en} !== 2'b00) begin
         miscompares++;
         $display("FAIL midmiss_no_refill: got busy=%b rd=%b, required 0 0", fsm_busy, mem_read_en);
      end
      tick();
   endtask

   task automatic test_gaps();
      fill_res_t r;
      gap_mode = 1'b1;
      run_fill("gaps", 16'h5A5A, 0, 16'h0, r);
      gap_mode = 1'b0;
      vectors++;
      if ({r.n_wr, r.n_req} !== {8'd8, 8'd8}) begin
         miscompares++;
         $display("FAIL gaps_counts: got wr=%0d req=%0d, required 8 8", r.n_wr, r.n_req);
      end
      vectors++;
      if (r.n_busy !== r.tag_rel) begin
         miscompares++;
         $display("FAIL gaps_busy_span: got %0d busy cycles, required %0d (through tag cycle)", r.n_busy, r.tag_rel);
      end
      sb_sample("gaps_end");
      vectors++;
      if (fsm_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL gaps_busy_fall: got busy=%b after tag, required 0", fsm_busy);
      end
      vectors++;
      if (exp_wr_q.size() != 0) begin
         miscompares++;
         $display("FAIL gaps_drain: got %0d writes missing, required 0", exp_wr_q.size());
      end
      tick();
   endtask

   task automatic test_reset_mid_fill();
      fill_res_t r;
      logic [15:0] b;
      int stale;
      b = 16'h2000;
      for (int i = 0; i < 8; i++) begin
         exp_req_q.push_back(b + 16'(2 * i));
         exp_wr_q.push_back({(i == 7) ? 1'b1 : 1'b0, 3'(i), b + 16'(2 * i)});
      end
      miss_detected = 1'b1;
      miss_address  = 16'h2004;
      tick();
      miss_detected = 1'b0;
      for (int rel = 1; rel <= 5; rel++) begin
         sb_sample("rstmid");
         tick();
      end
      // Now in cycle 6 of the fill.
      rst = 1'b0;
      #1;
      vectors++;
      if ({fsm_busy, mem_read_en, memory_address, write_data_array, fill_word_idx, write_tag_array} !== 22'h0) begin
         miscompares++;
         $display("FAIL rstmid_outputs: got busy=%b rd=%b addr=%h wda=%b idx=%0d tag=%b, required all 0",
                  fsm_busy, mem_read_en, memory_address, write_data_array, fill_word_idx, write_tag_array);
      end
      exp_req_q.delete();
      exp_wr_q.delete();
      tick();
      rst = 1'b1;
      stale = 0;
      for (int i = 0; i < 20 && (mem_q.size() > 0 || memory_data_valid); i++) begin
         sb_sample("stale");
         if (memory_data_valid) stale++;
         vectors++;
         if ({fsm_busy, mem_read_en, write_data_array} !== 3'b000) begin
            miscompares++;
            $display("FAIL stale_ignored: got busy=%b rd=%b wda=%b with valid=%b, required 000",
                     fsm_busy, mem_read_en, write_data_array, memory_data_valid);
         end
         tick();
      end
      if (stale == 0) $display("note: no stale responses observed after reset");
      run_fill("post_rst", 16'h0040, 0, 16'h0, r);
      vectors++;
      if ({r.first_wr, r.n_wr, r.tag_rel} !== {8'd5, 8'd8, 8'd12}) begin
         miscompares++;
         $display("FAIL post_rst_fill: got first_wr=%0d wr=%0d tag_cycle=%0d, required 5 8 12", r.first_wr, r.n_wr, r.tag_rel);
      end
   endtask

   task automatic test_back_to_back();
      fill_res_t r1;
      fill_res_t r2;
      run_fill("b2b_a", 16'h3008, 0, 16'h0, r1);
      // Immediately in the first idle cycle after the tag pulse.
      run_fill("b2b_b", 16'hFFF8, 0, 16'h0, r2);
      vectors++;
      if (r2.busy0 !== 8'd0) begin
         miscompares++;
         $display("FAIL b2b_idle_gap: got busy=%0d in first idle cycle, required 0", r2.busy0);
      end
      vectors++;
      if ({r2.first_req, r2.last_req, r2.n_wr, r2.tag_rel} !== {8'd1, 8'd8, 8'd8, 8'd12}) begin
         miscompares++;
         $display("FAIL b2b_second_fill: got freq=%0d lreq=%0d wr=%0d tag_cycle=%0d, required 1 8 8 12",
                  r2.first_req, r2.last_req, r2.n_wr, r2.tag_rel);
      end
      sb_sample("b2b_end");
      vectors++;
      if (fsm_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_busy_fall: got busy=%b, required 0", fsm_busy);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic_fill();
      test_miss_during_fill();
      test_gaps();
      test_reset_mid_fill();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
